// File: rtl/exmem_if.sv
// ID/EX -> EX/MEM bundle: decoded control and operands in, latched EX results out.
// master drives the ID/EX side, slave is the execute stage.
interface exmem_if #(parameter int XLEN = 64);
  logic            idex_valid;
  logic [31:0]     idex_IC;
  logic [XLEN-1:0] idex_PC;
  logic [XLEN-1:0] idex_rd1;
  logic [XLEN-1:0] idex_rd2;
  logic [1:0]      idex_aluop;
  logic            idex_alusrc;
  logic            idex_isZeroBranch;
  logic            idex_isUnconBranch;
  logic            idex_memRead;
  logic            idex_memwrite;
  logic            idex_regwrite;
  logic            idex_mem2reg;

  logic            exmem_valid;
  logic [XLEN-1:0] exmem_alu_result;
  logic            exmem_zero;
  logic [XLEN-1:0] exmem_branch_target;
  logic            exmem_pc_src;
  logic [XLEN-1:0] exmem_write_data;
  logic [4:0]      exmem_rd;
  logic            exmem_memRead;
  logic            exmem_memwrite;
  logic            exmem_regwrite;
  logic            exmem_mem2reg;

  modport master (
    output idex_valid, idex_IC, idex_PC, idex_rd1, idex_rd2, idex_aluop, idex_alusrc,
           idex_isZeroBranch, idex_isUnconBranch, idex_memRead, idex_memwrite,
           idex_regwrite, idex_mem2reg,
    input  exmem_valid, exmem_alu_result, exmem_zero, exmem_branch_target, exmem_pc_src,
           exmem_write_data, exmem_rd, exmem_memRead, exmem_memwrite, exmem_regwrite,
           exmem_mem2reg
  );

  modport slave (
    input  idex_valid, idex_IC, idex_PC, idex_rd1, idex_rd2, idex_aluop, idex_alusrc,
           idex_isZeroBranch, idex_isUnconBranch, idex_memRead, idex_memwrite,
           idex_regwrite, idex_mem2reg,
    output exmem_valid, exmem_alu_result, exmem_zero, exmem_branch_target, exmem_pc_src,
           exmem_write_data, exmem_rd, exmem_memRead, exmem_memwrite, exmem_regwrite,
           exmem_mem2reg
  );
endinterface

// File: rtl/exmem_stage.sv
// LEGv8 execute stage with EX/MEM register: ALU, branch target/decision,
// stall (hold) and flush (bubble), synchronous active-high reset.
module exmem_stage #(
  parameter int XLEN = 64
) (
  input  logic   CLOCK,
  input  logic   RESET,
  input  logic   stall,
  input  logic   flush,
  exmem_if.slave bus
);
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic [XLEN-1:0] branch_target;
    logic            pc_src;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem2reg;
  } slot_t;

  slot_t           slot_q, slot_d, load_v;
  logic [XLEN-1:0] op_b, alu_res, br_off;
  logic            alu_ok;

  always_comb begin
    op_b = bus.idex_alusrc ? {{(XLEN-9){bus.idex_IC[20]}}, bus.idex_IC[20:12]} : bus.idex_rd2;
    alu_ok  = 1'b1;
    alu_res = '0;
    case (bus.idex_aluop)
      2'b00: alu_res = bus.idex_rd1 + op_b;
      2'b01: alu_res = op_b;
      2'b10: begin
        case (bus.idex_IC[31:21])
          OP_ADD:  alu_res = bus.idex_rd1 + op_b;
          OP_SUB:  alu_res = bus.idex_rd1 - op_b;
          OP_AND:  alu_res = bus.idex_rd1 & op_b;
          OP_ORR:  alu_res = bus.idex_rd1 | op_b;
          default: alu_ok  = 1'b0;
        endcase
      end
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    br_off = bus.idex_isUnconBranch ? {{(XLEN-26){bus.idex_IC[25]}}, bus.idex_IC[25:0]}
                                    : {{(XLEN-19){bus.idex_IC[23]}}, bus.idex_IC[23:5]};
    load_v               = '0;
    load_v.valid         = 1'b1;
    load_v.alu_result    = alu_res;
    load_v.zero          = (alu_res == '0);
    load_v.branch_target = bus.idex_PC + (br_off << 2);
    load_v.pc_src        = bus.idex_isUnconBranch |
                           (bus.idex_isZeroBranch & (bus.idex_rd2 == '0));
    load_v.write_data    = bus.idex_rd2;
    load_v.rd            = bus.idex_IC[4:0];
    load_v.mem_read      = bus.idex_memRead;
    load_v.mem_write     = bus.idex_memwrite;
    load_v.reg_write     = bus.idex_regwrite;
    // if() on an unknown falls to the else arm, so a don't-care mem2reg latches as 0
    if (bus.idex_mem2reg) load_v.mem2reg = 1'b1;
    else                  load_v.mem2reg = 1'b0;
  end

  always_comb begin
    slot_d = slot_q;
    if (flush)
      slot_d = '0;
    else if (!stall)
      slot_d = (bus.idex_valid && alu_ok) ? load_v : '0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign bus.exmem_valid         = slot_q.valid;
  assign bus.exmem_alu_result    = slot_q.alu_result;
  assign bus.exmem_zero          = slot_q.zero;
  assign bus.exmem_branch_target = slot_q.branch_target;
  assign bus.exmem_pc_src        = slot_q.pc_src;
  assign bus.exmem_write_data    = slot_q.write_data;
  assign bus.exmem_rd            = slot_q.rd;
  assign bus.exmem_memRead       = slot_q.mem_read;
  assign bus.exmem_memwrite      = slot_q.mem_write;
  assign bus.exmem_regwrite      = slot_q.reg_write;
  assign bus.exmem_mem2reg       = slot_q.mem2reg;
endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: hand-computed vectors checked with immediate assertions.
module tb_exmem_stage;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exmem_if #(.XLEN(64)) bus ();

  exmem_stage #(.XLEN(64)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ic, input logic [63:0] pc,
                       input logic [63:0] rd1, input logic [63:0] rd2, input logic [1:0] aluop,
                       input logic alusrc, input logic zb, input logic ub, input logic mr,
                       input logic mw, input logic rw, input logic m2r);
    bus.idex_valid         = v;
    bus.idex_IC            = ic;
    bus.idex_PC            = pc;
    bus.idex_rd1           = rd1;
    bus.idex_rd2           = rd2;
    bus.idex_aluop         = aluop;
    bus.idex_alusrc        = alusrc;
    bus.idex_isZeroBranch  = zb;
    bus.idex_isUnconBranch = ub;
    bus.idex_memRead       = mr;
    bus.idex_memwrite      = mw;
    bus.idex_regwrite      = rw;
    bus.idex_mem2reg       = m2r;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"},  64'(bus.exmem_valid), 64'd0);
    chk({tag, ".pc_src"}, 64'(bus.exmem_pc_src), 64'd0);
    chk({tag, ".rw"},     64'(bus.exmem_regwrite), 64'd0);
    chk({tag, ".mw"},     64'(bus.exmem_memwrite), 64'd0);
    chk({tag, ".alu"},    bus.exmem_alu_result, 64'd0);
  endtask

  initial begin
    // reset with random inputs
    drive(1'b1, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    chk_bubble("reset");
    chk("reset.rd",     64'(bus.exmem_rd), 64'd0);
    chk("reset.target", bus.exmem_branch_target, 64'd0);
    chk("reset.wdata",  bus.exmem_write_data, 64'd0);
    chk("reset.mr",     64'(bus.exmem_memRead), 64'd0);

    // LDUR x3,[x10,#1]
    RESET = 1'b0;
    drive(1'b1, 32'hF8401143, 64'h0, 64'h100, 64'h55, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("ldur.valid", 64'(bus.exmem_valid), 64'd1);
    chk("ldur.alu",   bus.exmem_alu_result, 64'h101);
    chk("ldur.rd",    64'(bus.exmem_rd), 64'd3);
    chk("ldur.mr",    64'(bus.exmem_memRead), 64'd1);
    chk("ldur.rw",    64'(bus.exmem_regwrite), 64'd1);
    chk("ldur.m2r",   64'(bus.exmem_mem2reg), 64'd1);
    chk("ldur.pcsrc", 64'(bus.exmem_pc_src), 64'd0);

    // SUB x4 = 5 - 7
    drive(1'b1, 32'hCB020064, 64'h0, 64'd5, 64'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("sub.alu",   bus.exmem_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub.zero",  64'(bus.exmem_zero), 64'd0);
    chk("sub.rd",    64'(bus.exmem_rd), 64'd4);
    chk("sub.m2r",   64'(bus.exmem_mem2reg), 64'd0);
    chk("sub.wdata", bus.exmem_write_data, 64'd7);

    drive(1'b1, 32'h8B020064, 64'h0, 64'd5, 64'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("add.alu", bus.exmem_alu_result, 64'd12);

    drive(1'b1, 32'hAA020064, 64'h0, 64'hF0, 64'h0F, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("orr.alu", bus.exmem_alu_result, 64'hFF);

    drive(1'b1, 32'h8A020064, 64'h0, 64'hF0, 64'h0F, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("and.alu",   bus.exmem_alu_result, 64'h0);
    chk("and.zero",  64'(bus.exmem_zero), 64'd1);
    chk("and.valid", 64'(bus.exmem_valid), 64'd1);

    // CBZ x0,#2 at 0x14, mem2reg unknown from decode
    drive(1'b1, 32'hB4000040, 64'h14, 64'h0, 64'h0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'bx);
    step();
    chk("cbz0.target", bus.exmem_branch_target, 64'h1C);
    chk("cbz0.pcsrc",  64'(bus.exmem_pc_src), 64'd1);
    chk("cbz0.m2r",    64'(bus.exmem_mem2reg), 64'd0);
    chk("cbz0.rw",     64'(bus.exmem_regwrite), 64'd0);

    drive(1'b1, 32'hB4000040, 64'h14, 64'h0, 64'h1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("cbz1.pcsrc",  64'(bus.exmem_pc_src), 64'd0);
    chk("cbz1.target", bus.exmem_branch_target, 64'h1C);

    // B #3 at 0x28
    drive(1'b1, 32'h14000003, 64'h28, 64'h0, 64'h9, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("b.target", bus.exmem_branch_target, 64'h34);
    chk("b.pcsrc",  64'(bus.exmem_pc_src), 64'd1);

    // stall 3 cycles after a SUB while inputs change
    drive(1'b1, 32'hCB020064, 64'h0, 64'd5, 64'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h8B020060 + k, 64'h0, 64'd100 + k, 64'd1, 2'b10, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b1, 1'b0, 1'b0);
      step();
      chk("stall.alu", bus.exmem_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("stall.rd",  64'(bus.exmem_rd), 64'd4);
      chk("stall.mw",  64'(bus.exmem_memwrite), 64'd0);
    end
    stall = 1'b0;
    drive(1'b1, 32'hAA020065, 64'h0, 64'hF0, 64'h0F, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("unstall.alu", bus.exmem_alu_result, 64'hFF);
    chk("unstall.rd",  64'(bus.exmem_rd), 64'd5);

    stall = 1'b1;
    flush = 1'b1;
    step();
    chk_bubble("stallflush");

    // flush alone on a taken B
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 32'h8B020064, 64'h0, 64'd5, 64'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h14000003, 64'h28, 64'h0, 64'h9, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_bubble("flushb");
    chk("flushb.target", bus.exmem_branch_target, 64'h0);

    // undecodable R-type
    drive(1'b1, 32'hFFE00000, 64'h0, 64'd5, 64'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk_bubble("undec");
    chk("undec.mr", 64'(bus.exmem_memRead), 64'd0);

    drive(1'b1, 32'h8B020064, 64'h0, 64'd5, 64'd7, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_bubble("aluop11");

    drive(1'b0, 32'h14000003, 64'h28, 64'd5, 64'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_bubble("invalid");

    // reset mid-stream wins over stall
    drive(1'b1, 32'h8B020064, 64'h0, 64'd5, 64'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("pre_rst.alu", bus.exmem_alu_result, 64'd12);
    RESET = 1'b1;
    stall = 1'b1;
    step();
    chk_bubble("midrst");
    chk("midrst.rd", 64'(bus.exmem_rd), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exmem_stage.md
# exmem_stage

Execute stage plus EX/MEM pipeline register for the LEGv8 pipelined core. Consumes the decoded control bundle and operands leaving ID/EX, performs ALU and branch-target computation, and latches results, branch decision and downstream control bits for the MEM stage. Supports stall (hold) and flush (bubble) from hazard logic.

## Interface
- Parameters:
- `XLEN`, default 64: datapath width.
- Ports:
- `CLOCK`  in  1  single clock, rising-edge active.
- `RESET`  in  1  reset, synchronous and active-high.
- `stall`  in  1  hold all EX/MEM registers this cycle.
- `flush`  in  1  load a bubble this cycle.
- `idex_valid`  in  1  ID/EX holds a real instruction.
- `idex_IC`  in  32  instruction word.
- `idex_PC`  in  64  PC of that instruction.
- `idex_rd1`, `idex_rd2`  in  64 each  register file reads (Rn, Rm/Rt).
- `idex_aluop`  in  2  00 add, 01 pass B, 10 R-type decode.
- `idex_alusrc`, `idex_isZeroBranch`, `idex_isUnconBranch`, `idex_memRead`, `idex_memwrite`, `idex_regwrite`, `idex_mem2reg`  in  1 each  control bits from ID/EX.
- `exmem_valid`  out  1  slot holds a real instruction.
- `exmem_alu_result`  out  64.
- `exmem_zero`  out  1  ALU result == 0.
- `exmem_branch_target`  out  64.
- `exmem_pc_src`  out  1  branch taken.
- `exmem_write_data`  out  64  store data (`idex_rd2`).
- `exmem_rd`  out  5  destination/Rt field `IC[4:0]`.
- `exmem_memRead`, `exmem_memwrite`, `exmem_regwrite`, `exmem_mem2reg`  out  1 each.

## Operation
- Immediate: if `alusrc`=1, B operand = sign-extended `IC[20:12]` (DT address); otherwise B = `idex_rd2`.
- ALU by `aluop`: 00 → A+B; 01 → B; 10 → decode `IC[31:21]`: ADD 10001011000 → A+B, SUB 11001011000 → A−B, AND 10001010000 → A&B, ORR 10101010000 → A|B.
- Arithmetic wraps modulo 2^64; no flags other than zero.
- Undecodable (aluop 11, or aluop 10 with an unlisted opcode): latch as bubble — valid and all control outputs 0, data fields 0.
- Branch offset: `isUnconBranch` → sign-extended `IC[25:0]`; else sign-extended `IC[23:5]`. Target = `idex_PC` + (offset << 2), wraps mod 2^64. Target is computed for every instruction; only meaningful when `pc_src`=1.
- `pc_src` = valid & (`isUnconBranch` | (`isZeroBranch` & `idex_rd2`==0)).
- Priority per rising edge: RESET > flush > stall > load.
- Bubble: `exmem_valid`, `pc_src`, memRead, memwrite, regwrite, mem2reg = 0; data fields 0.
- Stall: every output register retains its value.
- Load with `idex_valid`=0: bubble.
- X on `mem2reg` from control (B/CBZ/STUR) is latched as 0.

## Timing
- Latency 1 cycle: inputs sampled at rising edge N appear on outputs after edge N; outputs purely registered, no combinational input→output path.
- Reset value of every output: 0, including `exmem_valid`, `exmem_pc_src`, `exmem_rd`.
- RESET asserted mid-stream: next edge clears everything, regardless of stall/flush.
- Flush and stall both high: flush wins (bubble).
- Stall held k cycles: outputs unchanged for k edges; first non-stalled edge loads the then-current ID/EX.
- Back-to-back taken branches: each evaluated independently; upstream flush is hazard logic's job, not this block's.

## Test plan
- Reset: RESET=1 for 2 cycles with random inputs → all outputs 0; release → first valid load appears one edge later.
- LDUR x3,[x10,#1] (IC=F8401143), rd1=0x100, alusrc=1, aluop=00 → alu_result=0x101, rd=3, memRead=1, regwrite=1, mem2reg=1, pc_src=0.
- SUB (IC=CB020064), rd1=5, rd2=7, aluop=10 → alu_result=0xFFFF_FFFF_FFFF_FFFE, zero=0, rd=4; ADD same operands → 12; ORR 0xF0|0x0F → 0xFF; AND 0xF0&0x0F → 0, zero=1.
- CBZ x0,#2 (IC=B4000040) at PC=0x14, rd2=0 → branch_target=0x1C, pc_src=1; rd2=1 → pc_src=0. B #3 (IC=14000003) at PC=0x28 → target=0x34, pc_src=1.
- Stall 3 cycles while inputs change → outputs frozen; stall+flush together → bubble; flush alone on a taken B → pc_src=0, valid=0.
- aluop=10 with IC=0xFFE00000 → bubble latched (valid=0, regwrite=0, memwrite=0).
